// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the unified memory arbiter.
// Fetch side : if_req, if_addr -> if_done, if_rdata
// Data side  : dm_req, dm_wr, dm_addr, dm_wdata -> dm_done, dm_rdata
// Memory side: mem_en, mem_wr, mem_addr, mem_wdata <- mem_rdata, mem_done
// Status     : err (sticky)
// slave is the arbiter's view; master is the view of whatever drives the arbiter.
interface mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        dm_req;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_done;
    logic [15:0] dm_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        err;
    modport slave (
        input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_done,
        output if_done, if_rdata, dm_done, dm_rdata, mem_en, mem_wr, mem_addr, mem_wdata, err
    );
    modport master (
        output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_done,
        input  if_done, if_rdata, dm_done, dm_rdata, mem_en, mem_wr, mem_addr, mem_wdata, err
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access.
// Ports: clk, rst (async, active-high), bus (mem_arbiter_if.slave) carrying the
// fetch request/response, data request/response, memory transaction and err.
// One transaction at a time: IDLE picks a winner, ISSUE pulses mem_en, WAIT
// waits for mem_done (bounded by TIMEOUT), RESP pulses the winner's done.
// Define MEM_ARB_RR_EN for round-robin between simultaneous requests;
// otherwise data always beats fetch.
module mem_arbiter #(
    parameter int TIMEOUT = 32
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t      state, state_n;
    logic        own_dm;
    logic        pick_dm;
    logic        any_req;
    logic        owner_req;
    logic        viol;
    logic        timeout;
    logic [7:0]  cnt;
    assign any_req = bus.if_req || bus.dm_req;
`ifdef MEM_ARB_RR_EN
    logic last_dm;
    // Only a collision consults last_dm; a sole requester always wins.
    assign pick_dm = bus.dm_req && (!bus.if_req || !last_dm);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_dm <= 1'b0;
        else if (state == IDLE && any_req)
            last_dm <= pick_dm;
    end
`else
    assign pick_dm = bus.dm_req;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_comb begin
        state_n   = state;
        viol      = 1'b0;
        timeout   = 1'b0;
        owner_req = own_dm ? bus.dm_req : bus.if_req;
        case (state)
            IDLE: begin
                state_n = any_req ? ISSUE : IDLE;
                viol    = bus.mem_done;
            end
            ISSUE: begin
                state_n = WAIT;
                viol    = bus.mem_done || !owner_req;
            end
            WAIT: begin
                viol = !owner_req;
                if (bus.mem_done)
                    state_n = RESP;
                else if (cnt == 8'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                viol    = bus.mem_done;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_dm        <= 1'b0;
            cnt           <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_done   <= 1'b0;
            bus.dm_done   <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
            bus.err       <= 1'b0;
        end else begin
            bus.mem_en  <= state_n == ISSUE;
            bus.if_done <= state == WAIT && bus.mem_done && !own_dm;
            bus.dm_done <= state == WAIT && bus.mem_done && own_dm;
            bus.err     <= bus.err || viol || timeout;
            cnt         <= state == WAIT ? cnt + 8'd1 : 8'd0;
            if (state == IDLE && any_req) begin
                own_dm        <= pick_dm;
                bus.mem_wr    <= pick_dm && bus.dm_wr;
                bus.mem_addr  <= pick_dm ? bus.dm_addr : bus.if_addr;
                bus.mem_wdata <= pick_dm ? bus.dm_wdata : '0;
            end
            if (state == WAIT && bus.mem_done) begin
                if (own_dm)
                    bus.dm_rdata <= bus.mem_wr ? '0 : bus.mem_rdata;
                else
                    bus.if_rdata <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue scoreboard for mem_arbiter.
// Stimulus pushes expected memory issues and done pulses (with their cycle);
// a negedge monitor pops and compares whenever mem_en or a done pulse appears.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic hang = 1'b0;
    logic inj = 1'b0;
    logic pend = 1'b0;
    logic resp_done = 1'b0;
    logic [15:0] rd_val = '0;
    int   c0;

    typedef struct {int cyc; logic wr; logic [15:0] addr; logic [15:0] wdata;} iss_t;
    typedef struct {int cyc; logic dm; logic [15:0] rdata;} dn_t;
    iss_t iq[$];
    dn_t  dq[$];
    iss_t ie;
    dn_t  de;

    mem_arbiter_if bus();
    mem_arbiter #(.TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_done  = resp_done | inj;
    assign bus.mem_rdata = rd_val;

    // Memory model: answers every issued transaction one cycle later unless hung.
    always @(negedge clk) if (bus.mem_en && !hang) pend = 1'b1;
    always @(posedge clk) begin
        #1;
        resp_done = pend;
        pend = 1'b0;
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] outs();
        return 96'({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.if_done,
                    bus.dm_done, bus.if_rdata, bus.dm_rdata, bus.err});
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.mem_en) begin
            if (iq.size() == 0)
                chk("unexpected_issue", 96'(bus.mem_en), 96'(0));
            else begin
                ie = iq.pop_front();
                chk("issue", 96'({cyc, bus.mem_wr, bus.mem_addr, bus.mem_wr ? bus.mem_wdata : 16'h0}),
                    96'({ie.cyc, ie.wr, ie.addr, ie.wdata}));
            end
        end
        if (!rst && (bus.if_done || bus.dm_done)) begin
            if (dq.size() == 0)
                chk("unexpected_done", 96'({bus.if_done, bus.dm_done}), 96'(0));
            else begin
                de = dq.pop_front();
                chk("done", 96'({cyc, bus.dm_done, bus.if_done, bus.dm_done ? bus.dm_rdata : bus.if_rdata}),
                    96'({de.cyc, de.dm, !de.dm, de.rdata}));
            end
        end
    end

    task automatic push_iss(input int c, input logic wr, input logic [15:0] a, input logic [15:0] d);
        iq.push_back('{c, wr, a, d});
    endtask

    task automatic push_dn(input int c, input logic dm, input logic [15:0] r);
        dq.push_back('{c, dm, r});
    endtask

    task automatic start();
        @(posedge clk);
        #1;
        c0 = cyc;
    endtask

    task automatic goto(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Waits (bounded) for the done pulse, then drops req in the following cycle.
    task automatic wait_done(input logic dm);
        int n = 0;
        while (!(dm ? bus.dm_done : bus.if_done) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(dm ? "dm_done_seen" : "if_done_seen", 96'(dm ? bus.dm_done : bus.if_done), 96'(1));
        @(posedge clk);
        #1;
        if (dm) bus.dm_req = 1'b0;
        else bus.if_req = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic collide(input logic [15:0] if_a, input logic wr, input logic [15:0] dm_a,
                           input logic [15:0] dm_d, input logic [15:0] rv);
        start();
        rd_val = rv;
        bus.if_req = 1'b1; bus.if_addr = if_a;
        bus.dm_req = 1'b1; bus.dm_wr = wr; bus.dm_addr = dm_a; bus.dm_wdata = dm_d;
        push_iss(c0 + 1, wr, dm_a, wr ? dm_d : 16'h0);
        push_dn(c0 + 3, 1'b1, wr ? 16'h0000 : rv);
        push_iss(c0 + 5, 1'b0, if_a, 16'h0);
        push_dn(c0 + 7, 1'b0, rv);
        wait_done(1'b1);
        wait_done(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_wr = 0;
        bus.dm_addr = 0; bus.dm_wdata = 0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs", outs(), 96'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_reset", 96'(bus.mem_en), 96'(0));
        end
        // single fetch
        start();
        rd_val = 16'hBEEF;
        bus.if_req = 1'b1; bus.if_addr = 16'h0010;
        push_iss(c0 + 1, 1'b0, 16'h0010, 16'h0);
        push_dn(c0 + 3, 1'b0, 16'hBEEF);
        wait_done(1'b0);
        // two collision rounds: dm first, then if, both times
        collide(16'h0020, 1'b1, 16'h0100, 16'h1234, 16'hA5A5);
        collide(16'h0030, 1'b0, 16'h0200, 16'h9999, 16'h5A5A);
        @(negedge clk);
        chk("err_clean", 96'(bus.err), 96'(0));
        // timeout, then the still-held fetch is re-served normally
        start();
        hang = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 16'h0040;
        push_iss(c0 + 1, 1'b0, 16'h0040, 16'h0);
        goto(c0 + 9);
        chk("no_err_before_timeout", 96'(bus.err), 96'(0));
        goto(c0 + 10);
        chk("timeout_err", 96'(bus.err), 96'(1));
        hang = 1'b0;
        rd_val = 16'h1357;
        push_iss(c0 + 11, 1'b0, 16'h0040, 16'h0);
        push_dn(c0 + 13, 1'b0, 16'h1357);
        wait_done(1'b0);
        chk("err_sticky", 96'(bus.err), 96'(1));
        // reset mid-WAIT
        start();
        hang = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 16'h0050;
        push_iss(c0 + 1, 1'b0, 16'h0050, 16'h0);
        goto(c0 + 3);
        rst = 1'b1;
        #1;
        chk("reset_mid_wait", outs(), 96'(0));
        bus.if_req = 1'b0;
        hang = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("no_issue_after_reset", 96'(bus.mem_en), 96'(0));
        end
        // mem_done while IDLE
        start();
        inj = 1'b1;
        goto(c0);
        chk("no_err_yet", 96'(bus.err), 96'(0));
        @(posedge clk);
        #1 inj = 1'b0;
        goto(c0 + 1);
        chk("idle_done_err", 96'(bus.err), 96'(1));
        reset_pulse();
        @(negedge clk);
        chk("err_cleared", 96'(bus.err), 96'(0));
        // granted dm_req dropped during WAIT
        start();
        hang = 1'b1;
        bus.dm_req = 1'b1; bus.dm_wr = 1'b0; bus.dm_addr = 16'h0060;
        push_iss(c0 + 1, 1'b0, 16'h0060, 16'h0);
        goto(c0 + 3);
        chk("no_err_in_wait", 96'(bus.err), 96'(0));
        bus.dm_req = 1'b0;
        goto(c0 + 4);
        chk("drop_req_err", 96'(bus.err), 96'(1));
        reset_pulse();
        hang = 1'b0;
        repeat (2) @(negedge clk);
        chk("issue_queue_left", 96'(iq.size()), 96'(0));
        chk("done_queue_left", 96'(dq.size()), 96'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
